// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS single-cycle CPU front end.
// Contents:
//   - opcode constants decoded by the main controller
//   - fetch_state_t, the state encoding of the instruction fetch FSM
//   - bit positions of the instruction word fields
package mips_pkg;

   // Opcode field values
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BLTZ  = 6'h01;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // Instruction field bit positions
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SA_HI    = 10;
   localparam int SA_LO    = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int TGT_HI   = 25;
   localparam int TGT_LO   = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/next_pc.sv
// Next program counter selection (purely combinational).
// Ports:
//   pc       in  32  address of the current instruction
//   instr    in  32  current instruction word (jump target / branch offset source)
//   jump     in  1   select the pseudo-direct jump target (highest priority)
//   branch   in  1   instruction is a conditional branch
//   br_taken in  1   branch condition resolved by the ALU
//   target   out 32  address of the next instruction
module next_pc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        jump,
   input  logic        branch,
   input  logic        br_taken,
   output logic [31:0] target
);

   logic        [31:0] p4;
   logic        [31:0] jump_tgt;
   logic signed [31:0] br_off;
   logic               unused_op;

   // The opcode bits play no part in address generation.
   assign unused_op = ^instr[OP_HI:OP_LO];

   always_comb begin
      // All sums wrap modulo 2^32.
      p4       = pc + 32'd4;
      jump_tgt = {p4[31:28], instr[TGT_HI:TGT_LO], 2'b00};
      br_off   = {{14{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};
      target   = p4;
      if (jump) begin
         target = jump_tgt;
      end else if (branch && br_taken) begin
         target = p4 + br_off;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and instruction fetch unit.
// Fetches one instruction over the req/ack memory handshake, presents it to
// the controller for a single ISSUE cycle, then loads the next PC chosen from
// the controller response. Deasserting pc_wrt during ISSUE halts the unit.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req/imem_addr             fetch request and byte address (= pc)
//   imem_ack/imem_rdata            fetch completion and instruction word
//   instr_valid                    one-cycle ISSUE strobe
//   instr, op, rs, rt, rd, sa,
//   funct, imm16                   registered instruction and its fields
//   pc                             address of the current instruction
//   pc_wrt, jump, branch, br_taken controller/ALU response, sampled in ISSUE
//   halted                         sticky halt indication
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  sa,
   output logic [15:0] imm16,
   output logic [31:0] pc,
   input  logic        pc_wrt,
   input  logic        jump,
   input  logic        branch,
   input  logic        br_taken,
   output logic        halted
);

   fetch_state_t state, state_nxt;
   logic [31:0]  npc;

   next_pc u_next_pc (
      .pc       (pc),
      .instr    (instr),
      .jump     (jump),
      .branch   (branch),
      .br_taken (br_taken),
      .target   (npc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   state_nxt = ST_FETCH;
         ST_FETCH:  if (imem_ack) state_nxt = ST_ISSUE;
         ST_ISSUE:  state_nxt = pc_wrt ? ST_FETCH : ST_HALTED;
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // An ack seen outside FETCH (e.g. a late ack after reset) never loads instr.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         instr <= 32'd0;
      end else begin
         if (state == ST_FETCH && imem_ack) begin
            instr <= imem_rdata;
         end
         if (state == ST_ISSUE && pc_wrt) begin
            pc <= npc;
         end
      end
   end

   // Every output below is a decode of the state register or a register slice.
   assign imem_req    = (state == ST_FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == ST_ISSUE);
   assign halted      = (state == ST_HALTED);

   assign op    = instr[OP_HI:OP_LO];
   assign rs    = instr[RS_HI:RS_LO];
   assign rt    = instr[RT_HI:RT_LO];
   assign rd    = instr[RD_HI:RD_LO];
   assign sa    = instr[SA_HI:SA_LO];
   assign funct = instr[FUNCT_HI:FUNCT_LO];
   assign imm16 = instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Issued instructions are pushed to
// an expectation queue by the driver; a negedge monitor pops and compares
// whenever instr_valid is high.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sa;
   logic [15:0] imm16;
   logic [31:0] pc;
   logic        pc_wrt;
   logic        jump;
   logic        branch;
   logic        br_taken;
   logic        halted;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [5:0]  op;
      logic [4:0]  rt;
      logic [15:0] imm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total  = 0;
   int   bad    = 0;
   int   issues = 0;
   int   pushes = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .op          (op),
      .funct       (funct),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .sa          (sa),
      .imm16       (imm16),
      .pc          (pc),
      .pc_wrt      (pc_wrt),
      .jump        (jump),
      .branch      (branch),
      .br_taken    (br_taken),
      .halted      (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every ISSUE cycle must match the oldest expectation.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         issues++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_issue: got instr %h pc %h want none", instr, pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("iss_instr", instr, mon_e.instr);
            chk("iss_op", {26'd0, op}, {26'd0, mon_e.op});
            chk("iss_rt", {27'd0, rt}, {27'd0, mon_e.rt});
            chk("iss_imm16", {16'd0, imm16}, {16'd0, mon_e.imm});
            chk("iss_pc", pc, mon_e.pc);
         end
      end
   end

   // One complete fetch/issue transaction with the given memory wait states
   // and controller response; checks the PC loaded at the end of ISSUE.
   task automatic issue_one(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] word, input int waits,
                            input logic wrt, input logic j, input logic b, input logic bt,
                            input logic [5:0] e_op, input logic [4:0] e_rt,
                            input logic [15:0] e_imm, input logic [31:0] exp_next);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, "_addr"}, imem_addr, exp_pc);
      for (int w = 0; w < waits; w++) begin
         imem_ack = 1'b0;
         step();
         chk({tag, "_wait_req"}, {31'd0, imem_req}, 32'd1);
         chk({tag, "_wait_addr"}, imem_addr, exp_pc);
         chk({tag, "_wait_valid"}, {31'd0, instr_valid}, 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      exp_q.push_back('{exp_pc, word, e_op, e_rt, e_imm});
      pushes++;
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      pc_wrt     = wrt;
      jump       = j;
      branch     = b;
      br_taken   = bt;
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      step();
      pc_wrt   = 1'b0;
      jump     = 1'b0;
      branch   = 1'b0;
      br_taken = 1'b0;
      chk({tag, "_next_pc"}, pc, exp_next);
      chk({tag, "_valid_end"}, {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      pc_wrt     = 1'b0;
      jump       = 1'b0;
      branch     = 1'b0;
      br_taken   = 1'b0;
      step();
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);

      // First request one cycle after reset release.
      rst = 1'b0;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      step();
      chk("first_req", {31'd0, imem_req}, 32'd1);

      issue_one("addiu", 32'h0, 32'h2401_0005, 0, 1, 0, 0, 0, 6'h09, 5'd1, 16'h0005, 32'h4);
      issue_one("wait3", 32'h4, 32'h0000_0000, 3, 1, 0, 0, 0, 6'h00, 5'd0, 16'h0000, 32'h8);
      chk("wait3_once", issues, 2);
      issue_one("j10", 32'h8, 32'h0800_0004, 1, 1, 1, 0, 0, 6'h02, 5'd0, 16'h0004, 32'h10);
      issue_one("beq_t", 32'h10, 32'h1000_FFFC, 0, 1, 0, 1, 1, 6'h04, 5'd0, 16'hFFFC, 32'h04);
      issue_one("j10b", 32'h4, 32'h0800_0004, 0, 1, 1, 0, 0, 6'h02, 5'd0, 16'h0004, 32'h10);
      issue_one("beq_nt", 32'h10, 32'h1000_FFFC, 2, 1, 0, 1, 0, 6'h04, 5'd0, 16'hFFFC, 32'h14);
      issue_one("j40", 32'h14, 32'h0800_0010, 0, 1, 1, 0, 0, 6'h02, 5'd0, 16'h0010, 32'h40);
      issue_one("j400", 32'h40, 32'h0800_0100, 0, 1, 1, 0, 0, 6'h02, 5'd0, 16'h0100, 32'h400);
      issue_one("j40b", 32'h400, 32'h0800_0010, 0, 1, 1, 0, 0, 6'h02, 5'd0, 16'h0010, 32'h40);
      issue_one("jprio", 32'h40, 32'h0800_0100, 0, 1, 1, 1, 1, 6'h02, 5'd0, 16'h0100, 32'h400);
      issue_one("halt", 32'h400, 32'hFC00_0000, 1, 0, 0, 0, 0, 6'h3F, 5'd0, 16'h0000, 32'h400);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         imem_ack = 1'b1;
         step();
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_hold", {31'd0, halted}, 32'd1);
         chk("halt_pc", pc, 32'h400);
      end
      imem_ack = 1'b0;

      rst = 1'b1;
      step();
      chk("rst2_pc", pc, 32'h0);
      chk("rst2_halted", {31'd0, halted}, 32'd0);
      chk("rst2_req", {31'd0, imem_req}, 32'd0);
      rst = 1'b0;

      // 0 + 4 - 8 wraps to 0xFFFF_FFFC, then +4 wraps to 0.
      issue_one("bwrap", 32'h0, 32'h1000_FFFE, 0, 1, 0, 1, 1, 6'h04, 5'd0, 16'hFFFE, 32'hFFFF_FFFC);
      issue_one("pwrap", 32'hFFFF_FFFC, 32'h0000_0000, 1, 1, 0, 0, 0, 6'h00, 5'd0, 16'h0000, 32'h0);
      issue_one("addiu2", 32'h0, 32'h2401_0005, 0, 1, 0, 0, 0, 6'h09, 5'd1, 16'h0005, 32'h4);

      // Reset during a wait state, late ack arrives in IDLE.
      chk("mid_req", {31'd0, imem_req}, 32'd1);
      chk("mid_addr", imem_addr, 32'h4);
      imem_ack = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      chk("late_ack_req", {31'd0, imem_req}, 32'd0);
      step();
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      chk("restart_req", {31'd0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, 32'h0);
      chk("late_ack_instr", instr, 32'h0);
      issue_one("restart", 32'h0, 32'h2401_0005, 0, 1, 0, 0, 0, 6'h09, 5'd1, 16'h0005, 32'h4);

      step();
      step();
      chk("issue_count", issues, pushes);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
